branch_stack: RTL and testbench
===============================

Name: branch_stack

Overview:
Central branch-tag manager for the R10K core. Allocates one-hot branch IDs at dispatch and stores a recovery checkpoint per in-flight branch. Consumes the branch FU's registered resolution (BR_TASK plus b_id) and rebroadcasts it as rem_br_task/rem_b_id to every masked structure (RS, FUs, ROB, LSQ), together with recovery state on a squash.

Parameters:
NUM_BR, 4, number of in-flight branches; BR_MASK width (matches sys_defs).
CKPT_W, 64, width of the opaque checkpoint payload (free-list head, map-table ptr, etc.).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
alloc_req  in  1  dispatch wants a branch tag this cycle
alloc_ckpt  in  CKPT_W  checkpoint to store with the new tag
alloc_gnt  out  1  tag granted this cycle (combinational)
alloc_b_id  out  NUM_BR  one-hot tag granted (combinational; 0 if no grant)
alloc_b_mask  out  NUM_BR  in-flight mask the dispatching branch depends on (combinational)
cur_b_mask  out  NUM_BR  current in-flight mask, for non-branch dispatch (combinational)
full  out  1  no free tag (combinational)
br_task  in  BR_TASK  resolution from branch FU: NOTHING/CLEAR/SQUASH
br_b_id  in  NUM_BR  one-hot tag being resolved
br_target  in  ADDR  correct next PC from branch FU (fu_pack.result)
rem_br_task  out  BR_TASK  registered broadcast task
rem_b_id  out  NUM_BR  registered broadcast tag
recover_valid  out  1  registered; high with a SQUASH broadcast
recover_pc  out  ADDR  registered redirect PC
recover_ckpt  out  CKPT_W  registered checkpoint of the squashed branch

Behaviour:
- State per entry i: valid[i], dep_mask[i] (tags older than i that are still in flight), ckpt[i].
- cur_b_mask = OR of valid[]; full = &valid.
- Reset: all valid = 0. rem_br_task = NOTHING, rem_b_id = 0, recover_valid = 0, recover_pc = 0, recover_ckpt = 0.
- Resolve-is-legal: br_task != NOTHING, br_b_id is one-hot, and the addressed entry is valid. Otherwise treat br_task as NOTHING.
- Allocation:
  - alloc_gnt = alloc_req & ~full & ~(legal SQUASH this cycle).
  - On a grant, take the lowest-index free slot.
  - alloc_b_mask = cur_b_mask & ~(br_b_id if legal CLEAR this cycle).
  - On the clock edge, set valid, and store dep_mask = alloc_b_mask and ckpt = alloc_ckpt.
- A slot freed this cycle is not grantable until the next cycle.
- CLEAR k (legal):
  - Next edge: valid[k] = 0, and bit k is cleared in every dep_mask.
  - Next-cycle outputs: rem_br_task = CLEAR, rem_b_id = k, recover_valid = 0.
- SQUASH k (legal):
  - Next edge: valid[k] = 0, and valid[j] = 0 for every j with dep_mask[j][k] = 1.
  - Next-cycle outputs: rem_br_task = SQUASH, rem_b_id = k, recover_valid = 1, recover_pc = br_target, recover_ckpt = ckpt[k].
  - Any allocation in the same cycle is refused.
- NOTHING, or an illegal resolve: next cycle rem_br_task = NOTHING, rem_b_id = 0, recover_valid = 0. recover_pc and recover_ckpt hold their previous values.
- Latency: exactly 1 cycle from br_task to rem_br_task. Broadcast outputs are pulses, held for one cycle only.
- At most one resolve per cycle (single branch FU).
- Reset mid-operation clears everything; no broadcast is produced on the reset cycle or the following cycle.

Decomposition:
- BR_TASK, BR_MASK, ADDR and NUM_BR come from sys_defs.svh.
- Add a BR_STACK_ENTRY struct (valid, dep_mask, ckpt) to sys_defs.
- One sub-module: psel_lowest (parameterised lowest-set-bit one-hot priority selector), applied to ~valid for allocation.

Test Plan:
1. After reset, alloc_req four consecutive cycles → alloc_b_id 0001, 0010, 0100, 1000; alloc_b_mask 0000, 0001, 0011, 0111. Fifth request → full = 1, alloc_gnt = 0.
2. With 4 tags live, br_task = CLEAR, br_b_id = 0010 → next cycle rem_br_task = CLEAR, rem_b_id = 0010. Entries 0100 and 1000 now show dep_mask 0001 and 0101. Next alloc grants 0010 with alloc_b_mask 1101.
3. With 4 tags live (allocated in order 0..3), SQUASH 0010 with br_target = 0x100, ckpt[1] = 0xABCD → next cycle recover_valid = 1, recover_pc = 0x100, recover_ckpt = 0xABCD, rem_b_id = 0010. cur_b_mask = 0001.
4. alloc_req in the same cycle as a legal SQUASH → alloc_gnt = 0 and no entry is written. Same cycle as a CLEAR of 0001 → grant succeeds with alloc_b_mask excluding bit 0.
5. br_task = CLEAR on an invalid tag, or br_b_id = 0011 → rem_br_task = NOTHING and state unchanged.
6. Reset asserted the cycle after a SQUASH input → all outputs at reset values; cur_b_mask = 0.

Source files
------------

// File: rtl/branch_stack_pkg.sv
// Shared types for the branch-tag manager: tag masks, resolve tasks and
// the per-branch recovery entry.
package branch_stack_pkg;

  localparam int NUM_BR = 4;   // in-flight branches, one bit per tag
  localparam int CKPT_W = 64;  // opaque recovery payload width
  localparam int ADDR_W = 32;  // program counter width

  typedef logic [NUM_BR-1:0] BR_MASK;
  typedef logic [ADDR_W-1:0] ADDR;

  typedef enum logic [1:0] {
    NOTHING = 2'h0,
    CLEAR   = 2'h1,
    SQUASH  = 2'h2
  } BR_TASK;

  // One slot per tag: dep_mask lists the older tags this branch sits under.
  typedef struct packed {
    logic              valid;
    BR_MASK            dep_mask;
    logic [CKPT_W-1:0] ckpt;
  } BR_STACK_ENTRY;

  // True when exactly one bit of the mask is set.
  function automatic logic is_onehot(input BR_MASK m);
    return (m != '0) && ((m & (m - BR_MASK'(1))) == '0);
  endfunction

endpackage

// File: rtl/branch_stack_psel.sv
// Lowest-set-bit priority selector: one-hot grant of the lowest requesting bit.
module psel_lowest #(
  parameter int W = 4
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o
);

  // Two's-complement trick isolates the lowest set bit (zero when no request).
  always_comb begin
    gnt_o = req_i & (~req_i + W'(1));
  end

endmodule

// File: rtl/branch_stack.sv
// Branch-tag manager: hands out one-hot tags at dispatch, keeps a recovery
// checkpoint per live branch, and rebroadcasts branch resolutions one cycle
// later to every structure that carries a branch mask.
//
// Allocation handshake: dispatch raises alloc_req and may hold it; a tag is
// consumed on the clock edge where alloc_req && alloc_gnt, and alloc_b_id /
// alloc_b_mask are only meaningful in that same cycle.
module branch_stack
  import branch_stack_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_req,
  input  logic [CKPT_W-1:0] alloc_ckpt,
  output logic              alloc_gnt,
  output BR_MASK            alloc_b_id,
  output BR_MASK            alloc_b_mask,
  output BR_MASK            cur_b_mask,
  output logic              full,
  input  BR_TASK            br_task,
  input  BR_MASK            br_b_id,
  input  ADDR               br_target,
  output BR_TASK            rem_br_task,
  output BR_MASK            rem_b_id,
  output logic              recover_valid,
  output ADDR               recover_pc,
  output logic [CKPT_W-1:0] recover_ckpt
);

  BR_STACK_ENTRY     entry_q [NUM_BR];
  BR_STACK_ENTRY     entry_d [NUM_BR];

  BR_TASK            rem_task_q, rem_task_d;
  BR_MASK            rem_b_id_q, rem_b_id_d;
  logic              recover_valid_q, recover_valid_d;
  ADDR               recover_pc_q, recover_pc_d;
  logic [CKPT_W-1:0] recover_ckpt_q, recover_ckpt_d;

  BR_MASK            valid_vec;
  BR_MASK            free_sel;
  logic              id_ok;
  logic              legal_clear;
  logic              legal_squash;
  logic [CKPT_W-1:0] sq_ckpt;

  // Gather the per-slot valid bits into a mask.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      valid_vec[i] = entry_q[i].valid;
    end
  end

  // A resolve only acts when it names exactly one live tag; anything else is
  // treated as no resolve at all. Nothing acts while reset is held.
  always_comb begin
    id_ok        = !reset && is_onehot(br_b_id) && ((br_b_id & valid_vec) != '0);
    legal_clear  = id_ok && (br_task == CLEAR);
    legal_squash = id_ok && (br_task == SQUASH);
  end

  // Free slots are those not valid at the start of the cycle, so a tag being
  // resolved right now cannot be handed out again until the next cycle.
  psel_lowest #(.W(NUM_BR)) u_psel (
    .req_i (~valid_vec),
    .gnt_o (free_sel)
  );

  // Allocation outputs; a squash this cycle wins over dispatch.
  always_comb begin
    cur_b_mask   = valid_vec;
    full         = &valid_vec;
    alloc_gnt    = alloc_req && !full && !legal_squash && !reset;
    alloc_b_id   = alloc_gnt ? free_sel : '0;
    alloc_b_mask = valid_vec & ~(legal_clear ? br_b_id : '0);
  end

  // Checkpoint of the tag being squashed (br_b_id is one-hot when legal).
  always_comb begin
    sq_ckpt = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (br_b_id[i]) sq_ckpt = sq_ckpt | entry_q[i].ckpt;
    end
  end

  // Next slot state: resolve effects first, then the newly granted slot.
  always_comb begin
    for (int i = 0; i < NUM_BR; i++) begin
      entry_d[i] = entry_q[i];
      if (legal_clear) begin
        if (br_b_id[i]) entry_d[i].valid = 1'b0;
        entry_d[i].dep_mask = entry_q[i].dep_mask & ~br_b_id;
      end
      if (legal_squash &&
          (br_b_id[i] || ((entry_q[i].dep_mask & br_b_id) != '0))) begin
        entry_d[i].valid = 1'b0;
      end
      if (alloc_b_id[i]) begin
        entry_d[i].valid    = 1'b1;
        entry_d[i].dep_mask = alloc_b_mask;
        entry_d[i].ckpt     = alloc_ckpt;
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BR; i++) begin
      if (reset) entry_q[i] <= '0;
      else       entry_q[i] <= entry_d[i];
    end
  end

  // Next broadcast: a one-cycle pulse of the legal resolve; the redirect PC
  // and checkpoint hold their last squash value otherwise.
  always_comb begin
    rem_task_d      = NOTHING;
    rem_b_id_d      = '0;
    recover_valid_d = 1'b0;
    recover_pc_d    = recover_pc_q;
    recover_ckpt_d  = recover_ckpt_q;
    if (legal_clear) begin
      rem_task_d = CLEAR;
      rem_b_id_d = br_b_id;
    end else if (legal_squash) begin
      rem_task_d      = SQUASH;
      rem_b_id_d      = br_b_id;
      recover_valid_d = 1'b1;
      recover_pc_d    = br_target;
      recover_ckpt_d  = sq_ckpt;
    end
  end

  // Broadcast registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_task_q      <= NOTHING;
      rem_b_id_q      <= '0;
      recover_valid_q <= 1'b0;
      recover_pc_q    <= '0;
      recover_ckpt_q  <= '0;
    end else begin
      rem_task_q      <= rem_task_d;
      rem_b_id_q      <= rem_b_id_d;
      recover_valid_q <= recover_valid_d;
      recover_pc_q    <= recover_pc_d;
      recover_ckpt_q  <= recover_ckpt_d;
    end
  end

  // A broadcast registered just before reset must not leak out during the
  // reset cycle, so the outputs are forced to their idle values while held.
  always_comb begin
    rem_br_task   = reset ? NOTHING : rem_task_q;
    rem_b_id      = reset ? '0 : rem_b_id_q;
    recover_valid = !reset && recover_valid_q;
    recover_pc    = reset ? '0 : recover_pc_q;
    recover_ckpt  = reset ? '0 : recover_ckpt_q;
  end

endmodule

// File: tb/tb_branch_stack.sv
// Directed bench for branch_stack: allocation order, clear, squash,
// illegal resolves, resolve/allocate collisions and reset mid-flight.
module tb_branch_stack;
  import branch_stack_pkg::*;

  logic              clock;
  logic              reset;
  logic              alloc_req;
  logic [CKPT_W-1:0] alloc_ckpt;
  logic              alloc_gnt;
  BR_MASK            alloc_b_id;
  BR_MASK            alloc_b_mask;
  BR_MASK            cur_b_mask;
  logic              full;
  BR_TASK            br_task;
  BR_MASK            br_b_id;
  ADDR               br_target;
  BR_TASK            rem_br_task;
  BR_MASK            rem_b_id;
  logic              recover_valid;
  ADDR               recover_pc;
  logic [CKPT_W-1:0] recover_ckpt;

  int n_cmp = 0;
  int n_err = 0;

  branch_stack dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_ckpt    (alloc_ckpt),
    .alloc_gnt     (alloc_gnt),
    .alloc_b_id    (alloc_b_id),
    .alloc_b_mask  (alloc_b_mask),
    .cur_b_mask    (cur_b_mask),
    .full          (full),
    .br_task       (br_task),
    .br_b_id       (br_b_id),
    .br_target     (br_target),
    .rem_br_task   (rem_br_task),
    .rem_b_id      (rem_b_id),
    .recover_valid (recover_valid),
    .recover_pc    (recover_pc),
    .recover_ckpt  (recover_ckpt)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_req = 1'b0;
    br_task   = NOTHING;
    br_b_id   = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]        exp_id   [4];
  logic [3:0]        exp_mask [4];
  logic [CKPT_W-1:0] ck_tab   [4];

  initial begin
    exp_id   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_mask = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
    ck_tab   = '{64'h1111, 64'hABCD, 64'h3333, 64'h4444};

    reset = 1'b1; alloc_ckpt = '0; br_target = '0;
    idle();
    repeat (2) tick();
    @(negedge clock);
    chk("in_reset_rem_task", rem_br_task, NOTHING);
    chk("in_reset_gnt", alloc_gnt, 0);
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_cur_mask", cur_b_mask, 0);
    chk("rst_full", full, 0);
    chk("rst_rem_task", rem_br_task, NOTHING);
    chk("rst_rem_b_id", rem_b_id, 0);
    chk("rst_recover_valid", recover_valid, 0);
    chk("rst_recover_pc", recover_pc, 0);
    chk("rst_recover_ckpt", recover_ckpt, 0);

    // Fill all four tags in order
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_ckpt = ck_tab[i];
      @(negedge clock);
      chk("fill_gnt", alloc_gnt, 1);
      chk("fill_b_id", alloc_b_id, exp_id[i]);
      chk("fill_b_mask", alloc_b_mask, exp_mask[i]);
      tick();
    end
    alloc_req = 1'b1;
    @(negedge clock);
    chk("full_flag", full, 1);
    chk("full_gnt", alloc_gnt, 0);
    chk("full_b_id", alloc_b_id, 0);
    chk("full_cur_mask", cur_b_mask, 4'b1111);
    tick();

    // CLEAR 0010 with all tags live
    alloc_req = 1'b0; br_task = CLEAR; br_b_id = 4'b0010;
    @(negedge clock);
    chk("clr_same_cycle_mask", alloc_b_mask, 4'b1101);
    tick();
    idle();
    chk("clr_rem_task", rem_br_task, CLEAR);
    chk("clr_rem_b_id", rem_b_id, 4'b0010);
    chk("clr_recover_valid", recover_valid, 0);
    chk("clr_cur_mask", cur_b_mask, 4'b1101);
    alloc_req = 1'b1; alloc_ckpt = 64'h5555;
    @(negedge clock);
    chk("realloc_gnt", alloc_gnt, 1);
    chk("realloc_b_id", alloc_b_id, 4'b0010);
    chk("realloc_b_mask", alloc_b_mask, 4'b1101);
    tick();
    idle();
    chk("clr_pulse_end_task", rem_br_task, NOTHING);
    chk("clr_pulse_end_id", rem_b_id, 0);
    chk("realloc_cur_mask", cur_b_mask, 4'b1111);

    // SQUASH the re-allocated tag with a colliding alloc: entries 2 and 3
    // survive only if the earlier CLEAR scrubbed bit 1 from their dep masks.
    br_task = SQUASH; br_b_id = 4'b0010; br_target = 32'h200; alloc_req = 1'b1;
    alloc_ckpt = 64'h7777;
    @(negedge clock);
    chk("sq_alloc_gnt", alloc_gnt, 0);
    chk("sq_alloc_b_id", alloc_b_id, 0);
    tick();
    idle();
    chk("sq1_rem_task", rem_br_task, SQUASH);
    chk("sq1_rem_b_id", rem_b_id, 4'b0010);
    chk("sq1_recover_valid", recover_valid, 1);
    chk("sq1_recover_pc", recover_pc, 32'h200);
    chk("sq1_recover_ckpt", recover_ckpt, 64'h5555);
    chk("sq1_cur_mask", cur_b_mask, 4'b1101);
    tick();
    chk("sq1_pulse_end_valid", recover_valid, 0);
    chk("sq1_pulse_end_task", rem_br_task, NOTHING);
    chk("sq1_hold_pc", recover_pc, 32'h200);
    chk("sq1_hold_ckpt", recover_ckpt, 64'h5555);

    // Fresh start: four tags, then SQUASH 0010 kills tags 1..3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst2_cur_mask", cur_b_mask, 0);
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_ckpt = ck_tab[i];
      tick();
    end
    idle();
    br_task = SQUASH; br_b_id = 4'b0010; br_target = 32'h100;
    tick();
    idle();
    chk("sq2_rem_task", rem_br_task, SQUASH);
    chk("sq2_rem_b_id", rem_b_id, 4'b0010);
    chk("sq2_recover_valid", recover_valid, 1);
    chk("sq2_recover_pc", recover_pc, 32'h100);
    chk("sq2_recover_ckpt", recover_ckpt, 64'hABCD);
    chk("sq2_cur_mask", cur_b_mask, 4'b0001);

    // Illegal resolves: tag not live, then a non-one-hot tag
    br_task = CLEAR; br_b_id = 4'b0100;
    @(negedge clock);
    chk("ill1_alloc_mask", alloc_b_mask, 4'b0001);
    tick();
    idle();
    chk("ill1_rem_task", rem_br_task, NOTHING);
    chk("ill1_rem_b_id", rem_b_id, 0);
    chk("ill1_recover_valid", recover_valid, 0);
    chk("ill1_hold_pc", recover_pc, 32'h100);
    chk("ill1_cur_mask", cur_b_mask, 4'b0001);
    br_task = CLEAR; br_b_id = 4'b0011;
    tick();
    idle();
    chk("ill2_rem_task", rem_br_task, NOTHING);
    chk("ill2_cur_mask", cur_b_mask, 4'b0001);

    // CLEAR 0001 with a colliding alloc: grant the next free slot, mask drops bit 0
    br_task = CLEAR; br_b_id = 4'b0001; alloc_req = 1'b1; alloc_ckpt = 64'h6666;
    @(negedge clock);
    chk("clr_alloc_gnt", alloc_gnt, 1);
    chk("clr_alloc_b_id", alloc_b_id, 4'b0010);
    chk("clr_alloc_b_mask", alloc_b_mask, 4'b0000);
    tick();
    idle();
    chk("clr2_rem_task", rem_br_task, CLEAR);
    chk("clr2_rem_b_id", rem_b_id, 4'b0001);
    chk("clr2_cur_mask", cur_b_mask, 4'b0010);

    // SQUASH, then reset the very next cycle
    br_task = SQUASH; br_b_id = 4'b0010; br_target = 32'h300;
    tick();
    idle();
    reset = 1'b1;
    @(negedge clock);
    chk("rst3_during_task", rem_br_task, NOTHING);
    chk("rst3_during_valid", recover_valid, 0);
    chk("rst3_during_b_id", rem_b_id, 0);
    chk("rst3_during_pc", recover_pc, 0);
    chk("rst3_during_ckpt", recover_ckpt, 0);
    tick();
    reset = 1'b0;
    chk("rst3_after_task", rem_br_task, NOTHING);
    chk("rst3_after_valid", recover_valid, 0);
    chk("rst3_after_pc", recover_pc, 0);
    chk("rst3_after_ckpt", recover_ckpt, 0);
    chk("rst3_after_cur_mask", cur_b_mask, 0);
    chk("rst3_after_full", full, 0);
    tick();
    chk("rst3_next_task", rem_br_task, NOTHING);
    chk("rst3_next_valid", recover_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
